cordic: RTL and testbench



---
 rtl/cordic_pkg.sv | 29 ++
 rtl/cordic_if.sv | 24 ++
 rtl/cordic_stage.sv | 56 +++++
 rtl/cordic.sv | 105 ++++++++++
 tb/tb_cordic.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the pipelined rotation-mode CORDIC: widths, quadrant codes, arctan table.
package cordic_pkg;

    localparam int XY_SZ_DEF = 16;
    localparam int ANG_SZ    = 32;
    localparam int ATAN_LEN  = 32;

    typedef enum logic [1:0] {
        QUAD_0   = 2'b00,
        QUAD_90  = 2'b01,
        QUAD_180 = 2'b10,
        QUAD_270 = 2'b11
    } quad_e;

    typedef logic [ANG_SZ-1:0] atan_tbl_t [ATAN_LEN];

    // round(atan(2^-i) / (2*pi) * 2^32); entries past 15 are never reached
    localparam atan_tbl_t ATAN_TBL = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
    };

endpackage

// File: rtl/cordic_if.sv
// Sample bus of the CORDIC; CORDIC_VALID_EN adds the in_valid/out_valid sideband.
interface cordic_if #(
    parameter int XY_SZ = 16
);
    import cordic_pkg::*;

    logic signed [ANG_SZ-1:0] angle;
    logic signed [XY_SZ-1:0]  Xin;
    logic signed [XY_SZ-1:0]  Yin;
    logic signed [XY_SZ:0]    Xout;
    logic signed [XY_SZ:0]    Yout;

`ifdef CORDIC_VALID_EN
    logic in_valid;
    logic out_valid;

    modport master (output angle, Xin, Yin, in_valid, input Xout, Yout, out_valid);
    modport slave  (input angle, Xin, Yin, in_valid, output Xout, Yout, out_valid);
`else
    modport master (output angle, Xin, Yin, input Xout, Yout);
    modport slave  (input angle, Xin, Yin, output Xout, Yout);
`endif

endinterface

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation with shift SHIFT and angle step ATAN.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int               W     = 17,
    parameter int               SHIFT = 0,
    parameter logic [ANG_SZ-1:0] ATAN  = 32'h00000000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic signed [W-1:0]      x_in,
    input  logic signed [W-1:0]      y_in,
    input  logic signed [ANG_SZ-1:0] z_in,
    output logic signed [W-1:0]      x_out,
    output logic signed [W-1:0]      y_out,
    output logic signed [ANG_SZ-1:0] z_out
);

    logic signed [W-1:0]      x_d, x_q, y_d, y_q;
    logic signed [ANG_SZ-1:0] z_d, z_q;
    logic signed [W-1:0]      x_sh_s, y_sh_s;

    assign x_sh_s = x_in >>> SHIFT;
    assign y_sh_s = y_in >>> SHIFT;

    // Rotate toward zero residual angle; direction follows the sign of z.
    always_comb begin
        if (z_in[ANG_SZ-1]) begin
            x_d = x_in + y_sh_s;
            y_d = y_in - x_sh_s;
            z_d = z_in + $signed(ATAN);
        end else begin
            x_d = x_in - y_sh_s;
            y_d = y_in + x_sh_s;
            z_d = z_in - $signed(ATAN);
        end
    end

    // Stage pipeline register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q <= {W{1'b0}};
            y_q <= {W{1'b0}};
            z_q <= {ANG_SZ{1'b0}};
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
        end
    end

    assign x_out = x_q;
    assign y_out = y_q;
    assign z_out = z_q;

endmodule

// File: rtl/cordic.sv
// Fully pipelined rotation-mode CORDIC, latency STG clocks, one sample per clock.
// Optional macro CORDIC_VALID_EN carries a valid flag alongside the data pipeline.
module cordic
    import cordic_pkg::*;
#(
    parameter int XY_SZ = XY_SZ_DEF,
    parameter int STG   = XY_SZ
) (
    input logic     clock,
    input logic     reset,
    cordic_if.slave bus
);

    localparam int W = XY_SZ + 1;

    logic signed [W-1:0]      x_s [STG];
    logic signed [W-1:0]      y_s [STG];
    logic signed [ANG_SZ-1:0] z_s [STG];

    logic signed [W-1:0]      xin_ext_s, yin_ext_s;
    logic signed [W-1:0]      x0_d, x0_q, y0_d, y0_q;
    logic signed [ANG_SZ-1:0] z0_d, z0_q;

    assign xin_ext_s = {bus.Xin[XY_SZ-1], bus.Xin};
    assign yin_ext_s = {bus.Yin[XY_SZ-1], bus.Yin};

    // Pre-rotate by +/-90 degrees so the residual angle stays within the convergence range.
    always_comb begin
        case (quad_e'(bus.angle[ANG_SZ-1 -: 2]))
            QUAD_90: begin
                x0_d = -yin_ext_s;
                y0_d = xin_ext_s;
                z0_d = {2'b00, bus.angle[ANG_SZ-3:0]};
            end
            QUAD_180: begin
                x0_d = yin_ext_s;
                y0_d = -xin_ext_s;
                z0_d = {2'b11, bus.angle[ANG_SZ-3:0]};
            end
            default: begin
                x0_d = xin_ext_s;
                y0_d = yin_ext_s;
                z0_d = bus.angle;
            end
        endcase
    end

    // Stage 0 register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x0_q <= {W{1'b0}};
            y0_q <= {W{1'b0}};
            z0_q <= {ANG_SZ{1'b0}};
        end else begin
            x0_q <= x0_d;
            y0_q <= y0_d;
            z0_q <= z0_d;
        end
    end

    assign x_s[0] = x0_q;
    assign y_s[0] = y0_q;
    assign z_s[0] = z0_q;

    for (genvar g = 1; g < STG; g++) begin : g_stage
        cordic_stage #(
            .W     (W),
            .SHIFT (g - 1),
            .ATAN  (ATAN_TBL[g-1])
        ) u_stage (
            .clock (clock),
            .reset (reset),
            .x_in  (x_s[g-1]),
            .y_in  (y_s[g-1]),
            .z_in  (z_s[g-1]),
            .x_out (x_s[g]),
            .y_out (y_s[g]),
            .z_out (z_s[g])
        );
    end

    assign bus.Xout = x_s[STG-1];
    assign bus.Yout = y_s[STG-1];

`ifdef CORDIC_VALID_EN
    logic [STG-1:0] vld_d, vld_q;

    // Valid flag advances in lock-step with the data stages.
    always_comb begin
        vld_d = {vld_q[STG-2:0], bus.in_valid};
    end

    // Valid shift register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= {STG{1'b0}};
        end else begin
            vld_q <= vld_d;
        end
    end

    assign bus.out_valid = vld_q[STG-1];
`endif

endmodule

// File: tb/tb_cordic.sv
// Directed self-checking bench for the cordic pipeline (default build and CORDIC_VALID_EN build).
module tb_cordic;

    localparam int          LAT   = 16;
    localparam int          AMP   = 32767;
    // 0.607253 * 2^15 = 19898 cancels the 1.6468 CORDIC gain
    localparam int          XCOMP = 19898;
    localparam int          TOL   = 16;
    localparam logic [31:0] INC   = 32'h088F5C28;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    cordic_if #(.XY_SZ(16)) bus ();

    cordic dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_eq(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int obs, input int exp, input int tol);
        logic ok;
        ok = ((obs - exp) <= tol) && ((exp - obs) <= tol);
        checks++;
        assert (ok === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic set_in(input logic [31:0] ang, input int xi, input int yi);
        bus.angle = ang;
        bus.Xin   = 16'(xi);
        bus.Yin   = 16'(yi);
    endtask

    task automatic vec(input string tag, input logic [31:0] ang, input int xi, input int yi,
                       input int ex, input int ey);
        set_in(ang, xi, yi);
        repeat (LAT) step();
        chk_near({tag, "_x"}, int'(bus.Xout), ex, TOL);
        chk_near({tag, "_y"}, int'(bus.Yout), ey, TOL);
    endtask

    function automatic real phase_of(input logic [31:0] a);
        longint la;
        la = {32'd0, a};
        return real'(la) * 6.283185307179586 / 4294967296.0;
    endfunction

    initial begin
        logic [31:0] a;
        longint      r2;
        logic        r2_ok;
        int          ex, ey;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        set_in(32'h0, 0, 0);
`ifdef CORDIC_VALID_EN
        bus.in_valid = 1'b0;
`endif
        #1;
        chk_eq("rst_x", int'(bus.Xout), 0);
        chk_eq("rst_y", int'(bus.Yout), 0);
        step();
        step();

        // Constant angle 0, exact 16-clock latency after reset release.
        set_in(32'h0, XCOMP, 0);
`ifdef CORDIC_VALID_EN
        bus.in_valid = 1'b1;
`endif
        reset = 1'b0;
        repeat (LAT - 1) step();
        chk_eq("lat_early_x", int'(bus.Xout), 0);
`ifdef CORDIC_VALID_EN
        chk_eq("lat_early_vld", int'(bus.out_valid), 0);
`endif
        step();
        chk_near("lat_x", int'(bus.Xout), AMP, TOL);
        chk_near("lat_y", int'(bus.Yout), 0, TOL);
`ifdef CORDIC_VALID_EN
        chk_eq("lat_vld", int'(bus.out_valid), 1);
`endif
        repeat (4) step();
        chk_near("hold_x", int'(bus.Xout), AMP, TOL);

        // Directed angles and input paths.
        vec("a90",    32'h40000000, XCOMP, 0,  0,      AMP);
        vec("a180",   32'h80000000, XCOMP, 0, -AMP,    0);
        vec("a270",   32'hC0000000, XCOMP, 0,  0,     -AMP);
        vec("a45",    32'h20000000, XCOMP, 0,  23170,  23170);
        vec("aneg1",  32'hFFFFFFFF, XCOMP, 0,  AMP,    0);
        vec("yin90",  32'h40000000, 0, XCOMP, -AMP,    0);
        vec("negx45", 32'h20000000, -XCOMP, 0, -23170, -23170);
        // 19998 * 1.64676 = 32932: peak input must not overflow 17 bits
        vec("peak",   32'h00000000, 19998, 0,  32932,  0);
        vec("peak90", 32'h40000000, 0, 19998, -32932,  0);

        // Phase ramp wrapping the 32-bit angle several times.
        for (int k = 0; k < 100 + LAT - 1; k++) begin
            if (k < 100) begin
                set_in(32'(k) * INC, XCOMP, 0);
            end
            step();
            if (k >= LAT - 1) begin
                a  = 32'(k - (LAT - 1)) * INC;
                ex = int'(real'(AMP) * $cos(phase_of(a)));
                ey = int'(real'(AMP) * $sin(phase_of(a)));
                chk_near("ramp_x", int'(bus.Xout), ex, TOL);
                chk_near("ramp_y", int'(bus.Yout), ey, TOL);
                r2 = longint'(bus.Xout) * longint'(bus.Xout) + longint'(bus.Yout) * longint'(bus.Yout);
                r2_ok = (r2 >= 64'sd1072602613) && (r2 <= 64'sd1074749965);
                checks++;
                assert (r2_ok === 1'b1) else begin
                    failures++;
                    $error("FAIL ramp_mag observed=%0d expected=1073676289+-1073676", r2);
                end
            end
        end

        // Reset mid-ramp: outputs clear without a clock edge, in-flight samples are dropped.
        for (int k = 0; k < 30; k++) begin
            set_in(32'(k) * INC, XCOMP, 0);
            step();
        end
        #2;
        reset = 1'b1;
        #1;
        chk_eq("mid_rst_x", int'(bus.Xout), 0);
        chk_eq("mid_rst_y", int'(bus.Yout), 0);
`ifdef CORDIC_VALID_EN
        chk_eq("mid_rst_vld", int'(bus.out_valid), 0);
`endif
        step();
        step();
        set_in(32'h80000000, XCOMP, 0);
        reset = 1'b0;
        repeat (LAT - 1) step();
        chk_eq("post_rst_early_x", int'(bus.Xout), 0);
        chk_eq("post_rst_early_y", int'(bus.Yout), 0);
`ifdef CORDIC_VALID_EN
        chk_eq("post_rst_early_vld", int'(bus.out_valid), 0);
`endif
        step();
        chk_near("post_rst_x", int'(bus.Xout), -AMP, TOL);
        chk_near("post_rst_y", int'(bus.Yout), 0, TOL);
`ifdef CORDIC_VALID_EN
        chk_eq("post_rst_vld", int'(bus.out_valid), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
